// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_prep.sv
// Operand decode: signedness, magnitudes, divide-by-zero / overflow detection.
// Purely combinational; no backpressure.
module muldiv_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_e             op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            is_div_o,
  output logic            a_neg_o,
  output logic            b_neg_o,
  output logic [XLEN-1:0] a_mag_o,
  output logic [XLEN-1:0] b_mag_o,
  output logic            special_o,
  output logic            div_zero_o,
  output logic [XLEN-1:0] special_res_o
);

  logic a_signed;
  logic b_signed;
  logic ovf;

  always_comb begin
    a_signed   = op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed   = op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg_o    = a_signed & a_i[XLEN-1];
    b_neg_o    = b_signed & b_i[XLEN-1];
    a_mag_o    = a_neg_o ? -a_i : a_i;
    b_mag_o    = b_neg_o ? -b_i : b_i;
    is_div_o   = op_i[2];
    div_zero_o = is_div_o & (b_i == '0);
    ovf        = (op_i inside {OP_DIV, OP_REM}) &
                 (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);
    special_o  = div_zero_o | ovf;

    // op[1] separates REM/REMU from DIV/DIVU
    special_res_o = '0;
    if (div_zero_o)
      special_res_o = op_i[1] ? a_i : '1;
    else if (ovf)
      special_res_o = op_i[1] ? '0 : a_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide: XLEN BUSY cycles, specials optionally immediate.
// Result held in DONE until out_ready; kill aborts BUSY or DONE back to IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              spec_q, spec_d, dzp_q, dzp_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              div_zero_q, div_zero_d;

  logic              p_is_div, p_a_neg, p_b_neg, p_special, p_div_zero;
  logic [XLEN-1:0]   p_a_mag, p_b_mag, p_special_res;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  muldiv_prep #(.XLEN(XLEN)) u_prep (
    .op_i          (op_e'(op)),
    .a_i           (a),
    .b_i           (b),
    .is_div_o      (p_is_div),
    .a_neg_o       (p_a_neg),
    .b_neg_o       (p_b_neg),
    .a_mag_o       (p_a_mag),
    .b_mag_o       (p_b_mag),
    .special_o     (p_special),
    .div_zero_o    (p_div_zero),
    .special_res_o (p_special_res)
  );

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide with quotient into lo
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, opd_q};
    if (op_q[2]) begin
      hi_n = ge ? XLEN'(shifted - {1'b0, opd_q}) : shifted[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end

    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = rneg_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                        final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo_s;
      OP_REM, OP_REMU:               final_res = rem_s;
      default:                       final_res = '0;
    endcase
    if (spec_q)
      final_res = spec_res_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opd_d      = opd_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    dzp_d      = dzp_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d       = op_e'(op);
          cnt_d      = '0;
          hi_d       = '0;
          lo_d       = p_is_div ? p_a_mag : p_b_mag;
          opd_d      = p_is_div ? p_b_mag : p_a_mag;
          neg_d      = p_a_neg ^ p_b_neg;
          rneg_d     = p_a_neg;
          spec_d     = p_special;
          dzp_d      = p_div_zero;
          spec_res_d = p_special_res;
          if ((FAST_SPECIAL != 0) && p_special) begin
            state_d    = ST_DONE;
            result_d   = p_special_res;
            div_zero_d = p_div_zero;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) begin
            state_d    = ST_DONE;
            result_d   = final_res;
            div_zero_d = dzp_q;
          end
        end
      end
      ST_DONE: begin
        if (kill || out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      opd_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      dzp_q      <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opd_q      <= opd_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      dzp_q      <= dzp_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit (XLEN=32) against an arithmetic reference.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            kill = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            div_zero;
  logic            busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .FAST_SPECIAL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {div_zero, result} from plain integer arithmetic
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int ix, iy;
    logic ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    ix = $signed(x);
    iy = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    model = '0;
    case (o)
      3'd0: begin p = sx * sy; model = {1'b0, p[31:0]};  end
      3'd1: begin p = sx * sy; model = {1'b0, p[63:32]}; end
      3'd2: begin p = sx * uy; model = {1'b0, p[63:32]}; end
      3'd3: begin p = ux * uy; model = {1'b0, p[63:32]}; end
      3'd4: model = (y == 0) ? {1'b1, 32'hFFFF_FFFF} : ovf ? {1'b0, x} : {1'b0, 32'(ix / iy)};
      3'd5: model = (y == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, x / y};
      3'd6: model = (y == 0) ? {1'b1, x} : ovf ? 33'd0 : {1'b0, 32'(ix % iy)};
      default: model = (y == 0) ? {1'b1, x} : {1'b0, x % y};
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input logic exp_dz, input int hold);
    int lat;
    int exp_lat;
    exp_lat = is_special(o, x, y) ? 0 : XLEN;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".div_zero"}, div_zero, exp_dz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_result"}, result, exp_res);
      chk({tag, ".hold_valid_ready"}, {out_valid, in_ready}, 2'b10);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".drained"}, {out_valid, in_ready, busy}, 3'b010);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [32:0] m;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          seen;

    #2;
    chk("reset.outputs", {out_valid, busy, div_zero, result}, 35'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("reset.in_ready", in_ready, 1);

    run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 0);
    run_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 0);
    run_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 0);
    run_op("divu",      3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0, 0);
    run_op("divu_zero", 3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1, 0);
    run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
    run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    run_op("remu_zero", 3'd7, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1'b1, 0);
    run_op("backpress", 3'd0, 32'd5,          32'd6,         32'd30,        1'b0, 5);

    // Kill after ten completed iterations
    @(negedge clk); in_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill.idle", {busy, in_ready, out_valid}, 3'b010);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("kill.no_out_valid", seen, 0);
    run_op("after_kill", 3'd0, 32'd3, 32'd4, 32'h0000_000C, 1'b0, 0);

    // Kill while IDLE must not block acceptance
    @(negedge clk); kill = 1'b1; in_valid = 1'b1; op = 3'd2; a = 32'hFFFF_FFFE; b = 32'h0000_0003;
    @(posedge clk); #1; kill = 1'b0; in_valid = 1'b0;
    chk("kill_idle.accepted", busy, 1);
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("kill_idle.latency", seen, XLEN);
    chk("kill_idle.result", result, 32'hFFFF_FFFF);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Asynchronous reset in the middle of an operation
    @(negedge clk); in_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("midreset.busy_before", busy, 1);
    rst_n = 1'b0; #1;
    chk("midreset.outputs", {out_valid, busy, div_zero, result}, 35'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midreset.in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midreset.no_out_valid", seen, 0);

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 9))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 5));
        3: ry = -32'($urandom_range(1, 5));
        4: rx = 32'($urandom_range(0, 20));
        default: ;
      endcase
      m = model(ro, rx, ry);
      run_op("random", ro, rx, ry, m[31:0], m[32], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
